// File: rtl/demux1to4_fifo.sv
// One source stream routed by a 2-bit select into four independent FIFO channels.
// Each channel shows its head word (zero when empty); a saturating counter tracks stalled input cycles.
module demux1to4_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [1:0]       IN_SELECT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2,
    output logic [WIDTH-1:0] OUT3,
    output logic [WIDTH-1:0] OUT4,
    output logic [3:0]       OUT_VALID,
    input  logic [3:0]       OUT_READY,
    output logic [7:0]       STALL_COUNT
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [PW-1:0]    wr_ptr [4];
    logic [PW-1:0]    rd_ptr [4];
    logic [PW:0]      count  [4];
    logic [WIDTH-1:0] head   [4];
    logic [3:0]       full;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [7:0]       stall_q;

    always_comb begin
        full      = '0;
        push      = '0;
        pop       = '0;
        OUT_VALID = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            full[n]      = (count[n] == (PW+1)'(DEPTH));
            OUT_VALID[n] = (count[n] != '0);
            push[n]      = IN_VALID && !full[n] && (IN_SELECT == 2'(n));
            pop[n]       = OUT_VALID[n] && OUT_READY[n];
            head[n]      = OUT_VALID[n] ? mem[n][rd_ptr[n]] : '0;
        end
    end

    // Readiness is judged on the pre-edge count, so a full channel never accepts even while popping.
    assign IN_READY    = !full[IN_SELECT];
    assign OUT1        = head[0];
    assign OUT2        = head[1];
    assign OUT3        = head[2];
    assign OUT4        = head[3];
    assign STALL_COUNT = stall_q;

    always_ff @(posedge CLK) begin
        if (IN_VALID && IN_READY) begin
            mem[IN_SELECT][wr_ptr[IN_SELECT]] <= IN_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned n = 0; n < 4; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (push[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
                if (pop[n])  rd_ptr[n] <= rd_ptr[n] + 1'b1;
                case ({push[n], pop[n]})
                    2'b10:   count[n] <= count[n] + 1'b1;
                    2'b01:   count[n] <= count[n] - 1'b1;
                    default: count[n] <= count[n];
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_q <= '0;
        end else if (IN_VALID && !IN_READY && (stall_q != 8'hFF)) begin
            stall_q <= stall_q + 8'd1;
        end
    end

endmodule
